mux_serializer_ctrl: RTL

- Sequential controller that sits on both sides of the 8:1 gate-level mux datapath.
- Upstream: accepts parallel words over a valid/ready handshake, holds each word on the mux data inputs, and steps the 3-bit select through all positions.
- Downstream: registers the mux output as a serial bit stream, and checks every returned bit against the held word, so stuck-at faults in the mux are flagged during fault simulation.

---
 rtl/mux_serializer_ctrl.sv | 65 ++++++
 1 files changed

// File: rtl/mux_serializer_ctrl.sv
// mux_serializer_ctrl: holds a word on an N:1 mux, walks its select to serialize the output,
// and flags any returned bit that disagrees with the held word.
module mux_serializer_ctrl #(
    parameter int SEL_W = 3,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2**SEL_W-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [2**SEL_W-1:0]   mux_data,
    output logic [SEL_W-1:0]      mux_sel,
    input  logic                  mux_o,
    input  logic                  ser_en,
    output logic                  ser_bit,
    output logic                  ser_valid,
    output logic                  ser_last,
    output logic                  err,
    input  logic                  clr_err
);
    localparam int N = 2**SEL_W;
    localparam logic [SEL_W-1:0] FIRST = MSB_FIRST ? SEL_W'(N-1) : '0;
    localparam logic [SEL_W-1:0] LAST = MSB_FIRST ? '0 : SEL_W'(N-1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic shift_go, at_last, accept, mismatch;
    logic [SEL_W-1:0] sel_step;
    always_comb begin
        shift_go = state == SHIFT && ser_en;
        at_last = mux_sel == LAST;
        in_ready = state == IDLE || (shift_go && at_last);
        accept = in_valid && in_ready;
        mismatch = shift_go && mux_o != mux_data[mux_sel];
        sel_step = MSB_FIRST ? mux_sel - SEL_W'(1) : mux_sel + SEL_W'(1);
        state_n = accept ? SHIFT : (shift_go && at_last) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end
    // Stepping past the last index wraps to the first, which is where an idle select rests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mux_data <= '0;
            mux_sel <= FIRST;
            ser_bit <= 1'b0;
            ser_valid <= 1'b0;
            ser_last <= 1'b0;
            err <= 1'b0;
        end else begin
            mux_sel <= accept ? FIRST : shift_go ? sel_step : mux_sel;
            if (accept)
                mux_data <= in_data;
            ser_valid <= shift_go;
            if (shift_go) begin
                ser_bit <= mux_o;
                ser_last <= at_last;
            end
            err <= mismatch || (err && !clr_err);
        end
    end
endmodule
